// File: rtl/sfp_vec.sv
// -----------------------------------------------------------------------------
// sfp_vec -- vectorised special-function processor for the accelerator output
// path. It sits between the OFIFO drain and the PSUM SRAM write port.
//
// Each of `col` lanes keeps a signed partial-sum accumulator. A group of
// `acc_len` beats is summed per lane. The result goes through an optional ReLU
// and is then offered on a valid/ready handshake. While the result waits for
// the consumer, no new beats are accepted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (aborts any group, no output)
//   in_valid   data_in beat present
//   in_ready   block accepts a beat this cycle (low while a result is held)
//   data_in    col lanes of signed psum_bw-bit values, lane i at [i*psum_bw +: psum_bw]
//   acc_len    beats per group, sampled on the first beat (0 is treated as 1)
//   relu_en    clamp negative results to 0, sampled on the first beat
//   out_valid  data_out holds a finished group
//   out_ready  consumer takes data_out
//   data_out   lane results, same packing as data_in
//   busy       a group is in progress or being held
//
// Configuration
//   SFP_SAT_EN  defined: each lane's add saturates to the signed psum_bw range.
//               undefined (default): each lane's add wraps in two's complement.
// -----------------------------------------------------------------------------
module sfp_vec #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   data_in,
    input  logic [len_bw-1:0]        acc_len,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   data_out,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic signed [psum_bw-1:0] lane_t;

    localparam lane_t lane_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam lane_t lane_min = {1'b1, {(psum_bw-1){1'b0}}};

    state_t             state;
    state_t             state_nxt;
    lane_t              psum    [col];
    lane_t              lane_in [col];
    logic [len_bw-1:0]  cnt;
    logic [len_bw-1:0]  cnt_inc;
    logic [len_bw-1:0]  len_q;
    logic [len_bw-1:0]  len_eff;
    logic               relu_q;
    logic               accept;

    // One lane add. The sum is formed one bit wider so that overflow shows up
    // as a disagreement between the top two bits.
    function automatic lane_t lane_add(input lane_t a, input lane_t b);
        logic signed [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
`ifdef SFP_SAT_EN
        if (s[psum_bw] != s[psum_bw-1]) begin
            return s[psum_bw] ? lane_min : lane_max;
        end
`endif
        return s[psum_bw-1:0];
    endfunction

    for (genvar i = 0; i < col; i++) begin : g_lane
        assign lane_in[i] = data_in[i*psum_bw +: psum_bw];
        // ReLU comes after the add, so it sees the saturated or wrapped value.
        assign data_out[i*psum_bw +: psum_bw] =
            (relu_q && psum[i][psum_bw-1]) ? '0 : psum[i];
    end

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt + len_bw'(1);
    // A zero length would never terminate, so it becomes a one-beat group.
    assign len_eff   = (acc_len == '0) ? len_bw'(1) : acc_len;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (len_eff == len_bw'(1)) ? HOLD : ACC;
            ACC:  if (accept && cnt_inc == len_q) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= len_bw'(1);
            relu_q <= 1'b0;
            // NOTE: the accumulators are discrete flops, not a RAM. They are
            // reset because data_out must read zero straight out of reset.
            for (int i = 0; i < col; i++) psum[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < col; i++) psum[i] <= lane_in[i];
                        cnt    <= len_bw'(1);
                        len_q  <= len_eff;
                        relu_q <= relu_en;
                    end
                end
                ACC: begin
                    // acc_len and relu_en are ignored here, so a mid-group
                    // change cannot affect the group.
                    if (accept) begin
                        for (int i = 0; i < col; i++) psum[i] <= lane_add(psum[i], lane_in[i]);
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        for (int i = 0; i < col; i++) psum[i] <= '0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
